// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between the decode-stage producer, the immediate/target
// generator and the downstream consumer.
//
// Valid/ready semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. Once valid is raised it and its data
// stay stable until the transfer happens (or a flush/reset kills it). Ready may
// be raised or lowered freely and never depends combinationally on valid.
interface imm_ext_pipe_if #(
    parameter int DATA_W = 32,
    parameter int JMP_W  = 26
);
    logic              in_valid;
    logic              in_ready;
    logic [JMP_W-1:0]  instr_idx;
    logic [DATA_W-1:0] pc;
    logic [2:0]        ext_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out;
    logic              op_err;

    // Producer/consumer side (drives requests, accepts results)
    modport master (
        output in_valid, instr_idx, pc, ext_op, out_ready,
        input  in_ready, out_valid, out, op_err
    );

    // Generator side
    modport slave (
        input  in_valid, instr_idx, pc, ext_op, out_ready,
        output in_ready, out_valid, out, op_err
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered immediate / branch / jump target generator with a 2-entry
// (main + skid) output buffer. The result is computed at the input and only
// the finished operand is stored, so the buffer never holds raw fields.
module imm_ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JMP_W  = 26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    imm_ext_pipe_if.slave bus
);
    localparam logic [2:0] OP_ZEXT  = 3'd0;
    localparam logic [2:0] OP_SEXT  = 3'd1;
    localparam logic [2:0] OP_UPPER = 3'd2;
    localparam logic [2:0] OP_ZERO  = 3'd3;
    localparam logic [2:0] OP_SEXT4 = 3'd4;
    localparam logic [2:0] OP_JUMP  = 3'd5;
    localparam logic [2:0] OP_BRAN  = 3'd6;

    // Keeps the PC bits above the jump index + byte offset (all zero when the
    // jump target covers the full width).
    localparam logic [DATA_W-1:0] JMP_HI_MASK =
        ~((DATA_W'(1) << (JMP_W + 2)) - DATA_W'(1));

    logic [IMM_W-1:0]  w_imm;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_result;
    logic              w_err;
    logic              w_in_fire;
    logic              w_out_fire;

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic              r_main_err;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_err;

    // Outputs come straight from registers; in_ready is the skid state gated by reset.
    assign bus.in_ready  = ~r_skid_valid & ~reset;
    assign bus.out_valid = r_main_valid;
    assign bus.out       = r_main_data;
    assign bus.op_err    = r_main_err;

    assign w_in_fire  = bus.in_valid & bus.in_ready;
    assign w_out_fire = r_main_valid & bus.out_ready;

    // Compute the operand for the selected mode from the incoming fields.
    always_comb begin
        w_imm    = bus.instr_idx[IMM_W-1:0];
        w_zext   = DATA_W'(w_imm);
        w_sext   = DATA_W'($signed(w_imm));
        w_result = '0;
        w_err    = 1'b0;
        case (bus.ext_op)
            OP_ZEXT:  w_result = w_zext;
            OP_SEXT:  w_result = w_sext;
            OP_UPPER: w_result = w_zext << (DATA_W - IMM_W);
            OP_ZERO:  w_result = '0;
            OP_SEXT4: w_result = w_sext << 2;
            OP_JUMP:  w_result = (bus.pc & JMP_HI_MASK) | (DATA_W'(bus.instr_idx) << 2);
            OP_BRAN:  w_result = bus.pc + DATA_W'(4) + (w_sext << 2);
            default: begin
                w_result = '0;
                w_err    = 1'b1;
            end
        endcase
    end

    // Main/skid buffer update: reset beats flush, flush beats any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_err   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_err   <= 1'b0;
        end else if (flush) begin
            // Data is left stale; only the valids matter to the consumer.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || (w_out_fire && !r_skid_valid)) begin
            // Main is (or is becoming) free and nothing older waits in skid.
            r_main_valid <= w_in_fire;
            if (w_in_fire) begin
                r_main_data <= w_result;
                r_main_err  <= w_err;
            end
        end else if (w_out_fire) begin
            // Skid is full here, so in_ready is low and no input can fire.
            r_main_data  <= r_skid_data;
            r_main_err   <= r_skid_err;
            r_skid_valid <= 1'b0;
        end else if (w_in_fire) begin
            // Main is stalled: park the new result in the skid register.
            r_skid_valid <= 1'b1;
            r_skid_data  <= w_result;
            r_skid_err   <= w_err;
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Testbench for imm_ext_pipe: directed scenarios plus randomized traffic on a
// 32-bit instance, and directed/random checks on a 64-bit instance.
module tb_imm_ext_pipe;
    logic clk = 1'b0;
    logic rst;
    logic fl;
    logic fl64;

    // Clock/reset block
    always #5 clk = ~clk;

    imm_ext_pipe_if #(.DATA_W(32), .JMP_W(26)) b32 ();
    imm_ext_pipe_if #(.DATA_W(64), .JMP_W(26)) b64 ();

    imm_ext_pipe #(.DATA_W(32), .IMM_W(16), .JMP_W(26)) u_dut32 (
        .clk   (clk),
        .reset (rst),
        .flush (fl),
        .bus   (b32)
    );

    imm_ext_pipe #(.DATA_W(64), .IMM_W(16), .JMP_W(26)) u_dut64 (
        .clk   (clk),
        .reset (rst),
        .flush (fl64),
        .bus   (b64)
    );

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: each mode computed from its arithmetic definition,
    // truncated to the output width w. Returns {op_err, value}.
    function automatic logic [64:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [25:0] idx, input logic [63:0] pc);
        logic [15:0] imm;
        longint      simm;
        logic [63:0] mask;
        logic [63:0] r;
        imm  = idx[15:0];
        simm = (imm >= 16'h8000) ? (longint'(imm) - 65536) : longint'(imm);
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        case (op)
            3'd0: r = 64'(imm);
            3'd1: r = simm;
            3'd2: r = 64'(imm) * (64'd1 << (w - 16));
            3'd3: r = 64'd0;
            3'd4: r = simm * 4;
            3'd5: r = (pc / (64'd1 << 28)) * (64'd1 << 28) + 64'(idx) * 64'd4;
            3'd6: r = pc + 64'd4 + simm * 4;
            default: r = 64'd0;
        endcase
        return {op == 3'd7, r & mask};
    endfunction

    // Driver: called just after a rising edge; holds the inputs for one cycle,
    // records an accepted request in the expected queue, returns 1ns after the edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [25:0] idx,
                        input logic [31:0] pc, input logic ordy, input logic f,
                        input logic r, output logic acc);
        logic [64:0] e;
        b32.in_valid  = v;
        b32.ext_op    = op;
        b32.instr_idx = idx;
        b32.pc        = pc;
        b32.out_ready = ordy;
        fl            = f;
        rst           = r;
        @(negedge clk);
        acc = v && b32.in_ready;
        if (acc && !f) begin
            e = ref_model(32, op, idx, {32'd0, pc});
            exp_q.push_back({e[64], e[31:0]});
        end
        @(posedge clk);
        if (f || r) exp_q.delete();
        #1;
    endtask

    // 64-bit instance: single request with the consumer always ready.
    task automatic step64(input logic [2:0] op, input logic [25:0] idx,
                          input logic [63:0] pc, output logic [64:0] got);
        b64.in_valid  = 1'b1;
        b64.ext_op    = op;
        b64.instr_idx = idx;
        b64.pc        = pc;
        b64.out_ready = 1'b1;
        @(posedge clk);
        #1;
        got = {b64.op_err, b64.out};
        chk("w64_valid", 65'(b64.out_valid), 65'd1);
        b64.in_valid = 1'b0;
    endtask

    // Scoreboard monitor: compares every delivered result against the queue
    // and checks that a stalled output holds steady.
    logic        prev_stall = 1'b0;
    logic [32:0] prev_val;
    always @(negedge clk) begin
        logic [32:0] got;
        logic [32:0] want;
        got = {b32.op_err, b32.out};
        if (prev_stall) begin
            chk("stall_hold_valid", 65'(b32.out_valid), 65'd1);
            chk("stall_hold_data", 65'(got), 65'(prev_val));
        end
        prev_stall = !rst && !fl && b32.out_valid && !b32.out_ready;
        prev_val   = got;
        if (!rst && b32.out_valid && b32.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected none", got);
            end else begin
                want = exp_q.pop_front();
                chk("scoreboard", 65'(got), 65'(want));
            end
        end
    end

    logic [2:0]  sw_op [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [32:0] sw_exp[6] = '{33'h0_0000_8001, 33'h0_FFFF_8001, 33'h0_8001_0000,
                               33'h0_0000_0000, 33'h0_FFFE_0004, 33'h1_0000_0000};
    logic [2:0]  bj_op [3] = '{3'd6, 3'd6, 3'd5};
    logic [25:0] bj_idx[3] = '{26'h000FFFF, 26'h0000003, 26'h0000010};
    logic [31:0] bj_pc [3] = '{32'h0000_3000, 32'h0000_3000, 32'h9000_0000};
    logic [31:0] bj_exp[3] = '{32'h0000_3000, 32'h0000_3010, 32'h9000_0040};

    initial begin
        logic        a;
        int          pend[$];
        int          acc_cnt;
        int          n0;
        logic [64:0] g;
        logic [2:0]  rop;
        logic [25:0] ridx;
        logic [63:0] rpc;

        fl64          = 1'b0;
        b64.in_valid  = 1'b0;
        b64.ext_op    = 3'd0;
        b64.instr_idx = '0;
        b64.pc        = '0;
        b64.out_ready = 1'b1;

        // Reset
        step(0, 0, 0, 0, 0, 0, 1, a);
        chk("rst_in_ready", 65'(b32.in_ready), 65'd0);
        chk("rst_out_valid", 65'(b32.out_valid), 65'd0);
        chk("rst_out", 65'(b32.out), 65'd0);
        chk("rst_op_err", 65'(b32.op_err), 65'd0);
        step(0, 0, 0, 0, 0, 0, 0, a);
        chk("post_rst_in_ready", 65'(b32.in_ready), 65'd1);

        // Mode sweep: each result visible right after its accepting edge
        for (int i = 0; i < 6; i++) begin
            step(1, sw_op[i], 26'h0008001, 32'h0000_3000, 1, 0, 0, a);
            chk("sweep_accept", 65'(a), 65'd1);
            chk("sweep_valid", 65'(b32.out_valid), 65'd1);
            chk($sformatf("sweep_m%0d", sw_op[i]), 65'({b32.op_err, b32.out}), 65'(sw_exp[i]));
        end

        // Branch and jump targets
        for (int i = 0; i < 3; i++) begin
            step(1, bj_op[i], bj_idx[i], bj_pc[i], 1, 0, 0, a);
            chk($sformatf("bj_%0d", i), 65'({b32.op_err, b32.out}), 65'({1'b0, bj_exp[i]}));
        end
        step(0, 0, 0, 0, 1, 0, 0, a);
        chk("idle_empty", 65'(b32.out_valid), 65'd0);

        // Back-pressure: 1..4 with out_ready low for the first 3 cycles
        pend    = '{1, 2, 3, 4};
        acc_cnt = 0;
        n0      = n_out;
        for (int t = 0; t < 7; t++) begin
            step(pend.size() > 0, 0, (pend.size() > 0) ? 26'(pend[0]) : 26'd0,
                 32'd0, t >= 3, 0, 0, a);
            if (a) begin
                void'(pend.pop_front());
                acc_cnt++;
                if (acc_cnt == 2) chk("bp_in_ready_low", 65'(b32.in_ready), 65'd0);
            end
        end
        chk("bp_all_accepted", 65'(pend.size()), 65'd0);
        chk("bp_delivered", 65'(n_out - n0), 65'd4);
        chk("bp_queue_empty", 65'(exp_q.size()), 65'd0);

        // Flush with main and skid full, input presented
        step(1, 0, 26'h10, 0, 0, 0, 0, a);
        step(1, 0, 26'h11, 0, 0, 0, 0, a);
        step(1, 0, 26'h12, 0, 0, 1, 0, a);
        chk("flushA_out_valid", 65'(b32.out_valid), 65'd0);
        chk("flushA_in_ready", 65'(b32.in_ready), 65'd1);
        step(0, 0, 0, 0, 1, 0, 0, a);
        chk("flushA_nothing", 65'(b32.out_valid), 65'd0);

        // Flush while an input actually fires: that input is discarded
        step(1, 0, 26'h20, 0, 0, 0, 0, a);
        step(1, 0, 26'h21, 0, 0, 1, 0, a);
        chk("flushB_accept", 65'(a), 65'd1);
        chk("flushB_out_valid", 65'(b32.out_valid), 65'd0);
        step(0, 0, 0, 0, 1, 0, 0, a);
        chk("flushB_nothing", 65'(b32.out_valid), 65'd0);

        // Reset mid-stream with both entries held
        step(1, 7, 26'h0, 0, 0, 0, 0, a);
        step(1, 0, 26'h55, 0, 0, 0, 0, a);
        step(0, 0, 0, 0, 0, 0, 1, a);
        chk("mrst_in_ready", 65'(b32.in_ready), 65'd0);
        chk("mrst_out_valid", 65'(b32.out_valid), 65'd0);
        chk("mrst_out", 65'(b32.out), 65'd0);
        chk("mrst_op_err", 65'(b32.op_err), 65'd0);
        step(1, 1, 26'h0008123, 0, 1, 0, 0, a);
        chk("mrst_first_accept", 65'(a), 65'd1);
        chk("mrst_first_out", 65'({b32.op_err, b32.out}), 65'h0_FFFF_8123);

        // Randomized traffic with occasional flush
        for (int t = 0; t < 400; t++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 26'($urandom),
                 $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, 0, a);
        end
        for (int t = 0; t < 4; t++) step(0, 0, 0, 0, 1, 0, 0, a);
        chk("drain_empty", 65'(exp_q.size()), 65'd0);

        // 64-bit variant
        step64(3'd2, 26'h0008001, 64'd0, g);
        chk("w64_upper", g, 65'h0_8001_0000_0000_0000);
        step64(3'd6, 26'h0000000, 64'hFFFF_FFFF_FFFF_FFFC, g);
        chk("w64_wrap", g, 65'h0);
        for (int i = 0; i < 16; i++) begin
            rop  = 3'($urandom_range(0, 7));
            ridx = 26'($urandom);
            rpc  = {$urandom, $urandom};
            step64(rop, ridx, rpc, g);
            chk($sformatf("w64_rand_m%0d", rop), g, ref_model(64, rop, ridx, rpc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
